// File: rtl/uart_rx_sampler.sv
// 8N1 UART receiver: two-flop synchroniser, start-edge detect, 3-sample majority vote
// at each bit centre, and a valid/ack output register for the received byte.
module uart_rx_sampler #(
  parameter int unsigned CLKS_PER_BIT = 48
) (
  input  logic       clk_48,
  input  logic       reset,
  input  logic       serial_rxd,
  output logic [7:0] data,
  output logic       data_valid,
  input  logic       data_ack,
  output logic       framing_error,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned CW   = $clog2(CLKS_PER_BIT) + 1;
  localparam int unsigned HALF = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0] CNT_S0   = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_S1   = CW'(HALF);
  localparam logic [CW-1:0] CNT_DEC  = CW'(HALF + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_e;

  state_e        state_q, state_d;
  logic          meta_q, meta_d;
  logic          rxd_s_q, rxd_s_d;
  logic [1:0]    sync_ok_q, sync_ok_d;
  logic          armed_q, armed_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [1:0]    samp_q, samp_d;
  logic [7:0]    data_q, data_d;
  logic          data_valid_q, data_valid_d;
  logic          framing_error_q, framing_error_d;
  logic          overrun_q, overrun_d;
  logic          busy_q, busy_d;

  logic          decide;
  logic          maj;
  logic          deliver;
  logic          stop_bad;

  always_ff @(posedge clk_48) begin
    if (reset) begin
      state_q         <= IDLE;
      meta_q          <= 1'b1;
      rxd_s_q         <= 1'b1;
      sync_ok_q       <= '0;
      armed_q         <= 1'b0;
      cnt_q           <= '0;
      bit_q           <= '0;
      shift_q         <= '0;
      samp_q          <= '0;
      data_q          <= '0;
      data_valid_q    <= 1'b0;
      framing_error_q <= 1'b0;
      overrun_q       <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      meta_q          <= meta_d;
      rxd_s_q         <= rxd_s_d;
      sync_ok_q       <= sync_ok_d;
      armed_q         <= armed_d;
      cnt_q           <= cnt_d;
      bit_q           <= bit_d;
      shift_q         <= shift_d;
      samp_q          <= samp_d;
      data_q          <= data_d;
      data_valid_q    <= data_valid_d;
      framing_error_q <= framing_error_d;
      overrun_q       <= overrun_d;
      busy_q          <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    meta_d    = serial_rxd;
    rxd_s_d   = meta_q;
    sync_ok_d = {sync_ok_q[0], 1'b1};
    // Arm only on a genuinely sampled high line, so a line held low through reset cannot start a frame.
    armed_d   = armed_q | (rxd_s_q & sync_ok_q[1]);
    cnt_d     = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
    bit_d     = bit_q;
    shift_d   = shift_q;
    samp_d    = samp_q;
    deliver   = 1'b0;
    stop_bad  = 1'b0;
    decide    = (cnt_q == CNT_DEC);
    maj       = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxd_s_q) | (samp_q[1] & rxd_s_q);

    if (cnt_q == CNT_S0) samp_d[0] = rxd_s_q;
    if (cnt_q == CNT_S1) samp_d[1] = rxd_s_q;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (armed_q && !rxd_s_q) begin
          state_d = START;
          cnt_d   = CW'(1);
        end
      end
      START: begin
        if (decide) begin
          state_d = maj ? IDLE : DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (decide) begin
          shift_d = {maj, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      STOP: begin
        if (decide) begin
          if (maj) begin
            deliver = 1'b1;
            state_d = IDLE;
          end else begin
            stop_bad = 1'b1;
            state_d  = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        if (rxd_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output register: ack is applied before a same-cycle delivery is considered.
  always_comb begin
    data_d          = data_q;
    data_valid_d    = data_valid_q & ~data_ack;
    framing_error_d = stop_bad;
    overrun_d       = 1'b0;
    busy_d          = (state_d != IDLE);
    if (deliver) begin
      if (data_valid_d) begin
        overrun_d = 1'b1;
      end else begin
        data_d       = shift_q;
        data_valid_d = 1'b1;
      end
    end
  end

  assign data          = data_q;
  assign data_valid    = data_valid_q;
  assign framing_error = framing_error_q;
  assign overrun       = overrun_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Bench for uart_rx_sampler: directed and random frames driven onto serial_rxd, compared
// every cycle against an event-scheduled reference computed from frame timing arithmetic.
module tb_uart_rx_sampler;

  localparam int CPB  = 48;
  localparam int HALF = CPB / 2;

  localparam int EV_BUSY_ON  = 0;
  localparam int EV_DELIVER  = 1;
  localparam int EV_FERR     = 2;
  localparam int EV_BUSY_OFF = 3;

  logic       clk_48 = 1'b0;
  logic       reset = 1'b1;
  logic       serial_rxd = 1'b1;
  logic       data_ack = 1'b0;
  logic [7:0] data;
  logic       data_valid;
  logic       framing_error;
  logic       overrun;
  logic       busy;

  uart_rx_sampler #(.CLKS_PER_BIT(CPB)) dut (
    .clk_48        (clk_48),
    .reset         (reset),
    .serial_rxd    (serial_rxd),
    .data          (data),
    .data_valid    (data_valid),
    .data_ack      (data_ack),
    .framing_error (framing_error),
    .overrun       (overrun),
    .busy          (busy)
  );

  always #5 clk_48 = ~clk_48;

  typedef struct {
    int         edge_n;
    int         kind;
    logic [7:0] b;
  } ev_t;

  ev_t        evq[$];
  int         cyc = 0;
  int         n_checks = 0;
  int         n_pass = 0;
  int         ov_cnt = 0;
  int         fe_cnt = 0;
  bit         chk_en = 1'b0;
  bit         ack_en = 1'b0;
  logic [7:0] exp_data = '0;
  logic       exp_valid = 1'b0;
  logic       exp_fe = 1'b0;
  logic       exp_ov = 1'b0;
  logic       exp_busy = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
  endtask

  // Reference: output register state advanced by scheduled frame events at known clock edges.
  initial begin
    ev_t ev;
    forever begin
      @(posedge clk_48);
      cyc++;
      if (reset) begin
        exp_data  = '0;
        exp_valid = 1'b0;
        exp_fe    = 1'b0;
        exp_ov    = 1'b0;
        exp_busy  = 1'b0;
        evq.delete();
        chk_en    = 1'b1;
      end else begin
        exp_fe = 1'b0;
        exp_ov = 1'b0;
        if (data_ack && exp_valid) exp_valid = 1'b0;
        while (evq.size() > 0 && evq[0].edge_n <= cyc) begin
          ev = evq.pop_front();
          case (ev.kind)
            EV_BUSY_ON:  exp_busy = 1'b1;
            EV_DELIVER: begin
              exp_busy = 1'b0;
              if (exp_valid) exp_ov = 1'b1;
              else begin
                exp_data  = ev.b;
                exp_valid = 1'b1;
              end
            end
            EV_FERR:     exp_fe = 1'b1;
            default:     exp_busy = 1'b0;
          endcase
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk_48);
      if (chk_en) begin
        check("data", 32'(data), 32'(exp_data));
        check("data_valid", 32'(data_valid), 32'(exp_valid));
        check("framing_error", 32'(framing_error), 32'(exp_fe));
        check("overrun", 32'(overrun), 32'(exp_ov));
        check("busy", 32'(busy), 32'(exp_busy));
        ov_cnt += int'(overrun);
        fe_cnt += int'(framing_error);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk_48);
      #1;
      data_ack = ack_en ? ($urandom_range(0, 3) == 0) : 1'b0;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input logic v);
    serial_rxd = v;
    @(posedge clk_48);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b1);
  endtask

  task automatic push(input int e, input int k, input logic [7:0] b);
    evq.push_back('{edge_n: e, kind: k, b: b});
  endtask

  // Line goes low during cycle p; rxd_s sees it at p+2, so the stop decision lands on edge p+HALF+9*CPB+4.
  task automatic send_frame(input logic [7:0] b, input logic stop, input logic [9:0] gmask,
                            input int low_hold, input int reset_at);
    int p;
    p = cyc;
    push(p + 3, EV_BUSY_ON, 8'h00);
    if (stop) begin
      push(p + HALF + 9 * CPB + 4, EV_DELIVER, b);
    end else begin
      push(p + HALF + 9 * CPB + 4, EV_FERR, 8'h00);
      push(p + 10 * CPB + low_hold + 3, EV_BUSY_OFF, 8'h00);
    end
    for (int c = 0; c < 10 * CPB; c++) begin
      int   k;
      logic v;
      k = c / CPB;
      if (k == 0)      v = 1'b0;
      else if (k == 9) v = stop;
      else             v = b[3'(k - 1)];
      if ((c % CPB) == HALF && gmask[4'(k)]) v = ~v;
      reset = (c == reset_at);
      tick(v);
    end
    reset = 1'b0;
    if (!stop) repeat (low_hold) tick(1'b0);
  endtask

  task automatic send_glitch(input int len);
    int p;
    p = cyc;
    push(p + 3, EV_BUSY_ON, 8'h00);
    push(p + HALF + 4, EV_BUSY_OFF, 8'h00);
    repeat (len) tick(1'b0);
    idle(2 * CPB);
  endtask

  task automatic drain_valid();
    int n;
    n = 0;
    ack_en = 1'b1;
    while (exp_valid && n < 200) begin
      tick(1'b1);
      n++;
    end
    check("drain_timeout", 32'(exp_valid), 32'(0));
    ack_en = 1'b0;
    tick(1'b1);
  endtask

  initial begin
    int         ov0;
    int         fe0;
    logic [7:0] b;
    logic       stop;
    logic [9:0] gm;
    repeat (3) @(posedge clk_48);
    #1;
    reset = 1'b0;
    idle(CPB);

    // 1: single byte, no ack
    send_frame(8'h41, 1'b1, 10'h000, 0, -1);
    idle(CPB);
    check("t1_data", 32'(data), 32'(8'h41));
    drain_valid();

    // 2: back-to-back with acks
    ov0 = ov_cnt;
    ack_en = 1'b1;
    send_frame(8'h0D, 1'b1, 10'h000, 0, -1);
    send_frame(8'h0A, 1'b1, 10'h000, 0, -1);
    idle(CPB);
    check("t2_overruns", 32'(ov_cnt - ov0), 32'(0));
    drain_valid();

    // 3: overrun without ack
    ov0 = ov_cnt;
    send_frame(8'h55, 1'b1, 10'h000, 0, -1);
    send_frame(8'hAA, 1'b1, 10'h000, 0, -1);
    idle(CPB);
    check("t3_overruns", 32'(ov_cnt - ov0), 32'(1));
    check("t3_data", 32'(data), 32'(8'h55));
    check("t3_valid", 32'(data_valid), 32'(1));
    drain_valid();

    // 4: short idle glitch, then a real frame
    send_glitch(10);
    check("t4_valid", 32'(data_valid), 32'(0));
    ack_en = 1'b1;
    send_frame(8'h33, 1'b1, 10'h000, 0, -1);
    idle(2 * CPB);
    drain_valid();

    // 5: break with stop low, then a real frame
    fe0 = fe_cnt;
    send_frame(8'h00, 1'b0, 10'h000, 30 * CPB, -1);
    idle(CPB);
    check("t5_ferr_pulses", 32'(fe_cnt - fe0), 32'(1));
    ack_en = 1'b1;
    send_frame(8'h7E, 1'b1, 10'h000, 0, -1);
    idle(2 * CPB);
    drain_valid();

    // 6: reset during data bit 3, then a clean frame
    send_frame(8'hC3, 1'b1, 10'h000, 0, 4 * CPB + HALF);
    idle(2 * CPB);
    check("t6_busy", 32'(busy), 32'(0));
    send_frame(8'hC3, 1'b1, 10'h000, 0, -1);
    idle(CPB);
    check("t6_data", 32'(data), 32'(8'hC3));
    drain_valid();

    // 7: centre glitch on every bit
    send_frame(8'h96, 1'b1, 10'h3FF, 0, -1);
    idle(CPB);
    check("t7_data", 32'(data), 32'(8'h96));
    drain_valid();

    // Random frames, gaps, centre glitches, framing errors and ack timing
    for (int f = 0; f < 30; f++) begin
      b      = 8'($urandom);
      stop   = ($urandom_range(0, 7) != 0);
      gm     = 10'($urandom) & 10'($urandom);
      ack_en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 5) == 0) send_glitch(int'($urandom_range(1, HALF - 2)));
      send_frame(b, stop, gm, stop ? 0 : int'($urandom_range(0, 3 * CPB)), -1);
      if (stop) idle(int'($urandom_range(0, 1)) * int'($urandom_range(0, CPB)));
      else      idle(CPB + int'($urandom_range(0, CPB)));
    end
    idle(2 * CPB);
    drain_valid();
    check("events_pending", 32'(evq.size()), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
